// File: rtl/alu_pkg.sv
// Shared encodings for the iterative ALU: funct3 base/M op codes and FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package alu_pkg;

  // Base integer ops; bit3 of raw_alu_operation turns ADD into SUB and SRL into SRA.
  typedef enum logic [2:0] {
    F3_ADD  = 3'd0,
    F3_SLL  = 3'd1,
    F3_SLT  = 3'd2,
    F3_SLTU = 3'd3,
    F3_XOR  = 3'd4,
    F3_SR   = 3'd5,
    F3_OR   = 3'd6,
    F3_AND  = 3'd7
  } base_op_e;

  // M-extension ops (bit3 ignored).
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } m_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_comb.sv
// Combinational base integer ops (ADD/SUB, shifts, compares, logic).
// Latency: 0 cycles. Backpressure: none, pure function of inputs.
// Ports: a, b operands; op[2:0] funct3, op[3] SUB/SRA modifier; y result.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  input  logic [3:0]           op,
  output logic [WORD_SIZE-1:0] y
);

  localparam int SW = $clog2(WORD_SIZE);

  // Only the low log2(WORD_SIZE) bits of b shift; upper bits are ignored.
  logic [SW-1:0] shamt;
  assign shamt = b[SW-1:0];

  always_comb begin
    y = '0;
    case (base_op_e'(op[2:0]))
      F3_ADD:  y = op[3] ? (a - b) : (a + b);
      F3_SLL:  y = a << shamt;
      F3_SLT:  y = {{(WORD_SIZE-1){1'b0}}, ($signed(a) < $signed(b))};
      F3_SLTU: y = {{(WORD_SIZE-1){1'b0}}, (a < b)};
      F3_XOR:  y = a ^ b;
      F3_SR: begin
        // Kept as separate statements so the arithmetic shift keeps its signed context.
        if (op[3]) y = $signed(a) >>> shamt;
        else       y = a >> shamt;
      end
      F3_OR:   y = a | b;
      F3_AND:  y = a & b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU: 1-cycle base ops, bit-serial shift-add multiply and restoring divide.
// Latency: base ops and div-by-zero/overflow 1 cycle; MUL*/DIV* WORD_SIZE+1 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (one op in flight).
// Ports: clk, reset (async, active-high); in_valid/in_ready request handshake with
//        a, b, raw_alu_operation, muldiv; out_valid/out_ready result handshake with out.
module iter_alu
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  input  logic [3:0]           raw_alu_operation,
  input  logic                 muldiv,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out
);

  localparam int W  = WORD_SIZE;
  localparam int CW = $clog2(W);

  state_e              state, state_nxt;
  m_op_e               mop;          // latched M op
  logic                sgn_q;        // product / quotient negative
  logic                sgn_a;        // remainder negative (follows dividend)
  logic [W-1:0]        opnd;         // multiplicand or divisor magnitude
  logic [2*W-1:0]      acc;          // {hi, lo}: product, or {remainder, quotient}
  logic [CW-1:0]       cnt;
  logic [W-1:0]        res;

  // ---------------- request decode ----------------
  m_op_e        m_op;
  logic         accept, is_div, a_signed, b_signed, sa, sb;
  logic         div_zero, ovf, special;
  logic [W-1:0] mag_a, mag_b, spec_val, base_y;

  assign m_op   = m_op_e'(raw_alu_operation[2:0]);
  assign accept = in_valid & in_ready;
  assign is_div = muldiv & raw_alu_operation[2];

  assign a_signed = muldiv & (m_op == OP_MUL || m_op == OP_MULH || m_op == OP_MULHSU ||
                              m_op == OP_DIV || m_op == OP_REM);
  assign b_signed = muldiv & (m_op == OP_MUL || m_op == OP_MULH ||
                              m_op == OP_DIV || m_op == OP_REM);
  assign sa    = a_signed & a[W-1];
  assign sb    = b_signed & b[W-1];
  // Most-negative value maps to itself, which is the correct unsigned magnitude.
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;

  assign div_zero = is_div & (b == '0);
  assign ovf      = is_div & (m_op == OP_DIV || m_op == OP_REM) &
                    (a == {1'b1, {(W-1){1'b0}}}) & (b == '1);
  assign special  = div_zero | ovf;
  // bit1 of the M op separates REM/REMU (6,7) from DIV/DIVU (4,5).
  assign spec_val = div_zero ? (raw_alu_operation[1] ? a : '1)
                             : (raw_alu_operation[1] ? '0 : a);

  alu_comb #(.WORD_SIZE(W)) u_alu_comb (
    .a  (a),
    .b  (b),
    .op (raw_alu_operation),
    .y  (base_y)
  );

  // ---------------- FSM ----------------
  logic last;
  assign last = (cnt == CW'(W - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!muldiv || special) state_nxt = DONE;
          else if (is_div)        state_nxt = DIV;
          else                    state_nxt = MUL;
        end
      end
      MUL, DIV: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- shared W+1-bit adder ----------------
  // Multiply: hi + multiplicand. Divide: {rem, next dividend bit} - divisor,
  // where the carry out (bit W+1) means no borrow, i.e. the trial subtract fits.
  logic [W:0]   add_x, add_y;
  logic         add_ci;
  logic [W+1:0] add_s;

  always_comb begin
    add_x  = {1'b0, acc[2*W-1:W]};
    add_y  = {1'b0, opnd};
    add_ci = 1'b0;
    if (state == DIV) begin
      add_x  = acc[2*W-1:W-1];
      add_y  = ~{1'b0, opnd};
      add_ci = 1'b1;
    end
    add_s = {1'b0, add_x} + {1'b0, add_y} + {{(W+1){1'b0}}, add_ci};
  end

  // ---------------- one iteration step + final sign fix ----------------
  logic [2*W-1:0] step, step_fix;
  logic           sel_hi;

  always_comb begin
    step = acc;
    if (state == DIV) begin
      if (add_s[W+1]) step = {add_s[W-1:0], acc[W-2:0], 1'b1};
      else            step = {acc[2*W-2:0], 1'b0};
    end else begin
      if (acc[0]) step = {add_s[W:0], acc[W-1:1]};
      else        step = {1'b0, acc[2*W-1:1]};
    end

    step_fix = step;
    if (last) begin
      if (state == DIV) begin
        if (sgn_q) step_fix[W-1:0]   = -step[W-1:0];
        if (sgn_a) step_fix[2*W-1:W] = -step[2*W-1:W];
      end else if (sgn_q) begin
        step_fix = -step;
      end
    end

    // MUL takes the low word, MULH* the high; DIV/DIVU the quotient, REM/REMU the remainder.
    sel_hi = (state == DIV) ? mop[1] : (mop != OP_MUL);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mop   <= OP_MUL;
      sgn_q <= 1'b0;
      sgn_a <= 1'b0;
      opnd  <= '0;
      acc   <= '0;
      cnt   <= '0;
      res   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mop   <= m_op;
            sgn_q <= sa ^ sb;
            sgn_a <= sa;
            cnt   <= '0;
            if (!muldiv) begin
              res <= base_y;
            end else if (special) begin
              res <= spec_val;
            end else if (is_div) begin
              opnd <= mag_b;
              acc  <= {{W{1'b0}}, mag_a};
            end else begin
              opnd <= mag_a;
              acc  <= {{W{1'b0}}, mag_b};
            end
          end
        end
        MUL, DIV: begin
          cnt <= cnt + 1'b1;
          acc <= step_fix;
          if (last) res <= sel_hi ? step_fix[2*W-1:W] : step_fix[W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign out = res;

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, datapath width in bits; legal values are powers of two from 8 to 64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation request present.
REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port a  input  WORD_SIZE  operand A.
REQ-007 SHALL have port b  input  WORD_SIZE  operand B.
REQ-008 SHALL have port raw_alu_operation  input  4  bits[2:0] funct3 code, bit3 invert/arithmetic modifier.
REQ-009 SHALL have port muldiv  input  1  1 = bits[2:0] select an M-extension op; bit3 is ignored.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port out  output  WORD_SIZE  result, stable while out_valid=1.

Function
REQ-013 SHALL use states IDLE, MUL, DIV, DONE; in_ready=1 only in IDLE; a request is accepted on in_valid & in_ready.
REQ-014 SHALL compute base ops (muldiv=0) as: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND; bit3 selects SUB and SRA.
REQ-015 SHALL use only b[log2(WORD_SIZE)-1:0] as the shift amount.
REQ-016 SHALL register a base-op result on acceptance (IDLE->DONE), giving 1-cycle latency.
REQ-017 SHALL implement M ops 0..7 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-018 SHALL compute multiplies by iterative shift-add on magnitudes into a 2*WORD_SIZE accumulator, one bit per cycle, with sign correction applied in the final cycle.
REQ-019 SHALL return the low WORD_SIZE bits for MUL and the high WORD_SIZE bits for MULH/MULHSU/MULHU.
REQ-020 SHALL compute divides by restoring division on magnitudes, one quotient bit per cycle; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-021 SHALL spend exactly WORD_SIZE cycles in MUL or DIV, then enter DONE; latency from acceptance to out_valid is WORD_SIZE+1 cycles.
REQ-022 SHALL, for divide by zero, skip iteration (IDLE->DONE, 1 cycle) and return all-ones for DIV/DIVU and a for REM/REMU.
REQ-023 SHALL, for signed overflow (a = most-negative, b = -1), skip iteration and return a for DIV and 0 for REM.
REQ-024 SHALL hold out and out_valid=1 in DONE until out_ready=1; then go to IDLE on that edge.
REQ-025 SHALL keep in_ready=0 in DONE; no request is accepted on the cycle the result is consumed (throughput at most one op per 2 cycles).
REQ-026 SHALL latch operands and opcode on acceptance; input changes during MUL/DIV/DONE do not affect the result.

Reset
REQ-027 SHALL, on reset assertion at any time including mid-operation, immediately go to IDLE, abandon the in-flight op, drive out_valid=0 and out=0, and clear all accumulators.
REQ-028 SHALL drive in_ready=1 in the first cycle after reset deasserts.

Structure
REQ-029 SHALL take funct3 op encodings (base and M) and the state enumeration from shared package alu_pkg.
REQ-030 SHALL instantiate one combinational sub-module, alu_comb, for the base ops of REQ-014/015.
REQ-031 SHALL share a single WORD_SIZE+1-bit adder between multiply and divide iterations.

Verification
REQ-032 SHALL pass a directed SUB test: W=32, a=5, b=7, op=1_000, muldiv=0 -> out=0xFFFFFFFE one cycle after acceptance.
REQ-033 SHALL pass a directed MULH test: a=0x80000000, b=0x80000000, MULH -> out=0x40000000 exactly 33 cycles after acceptance; a MULHU on the same operands -> 0x40000000.
REQ-034 SHALL pass a directed DIV test: a=-7, b=2, DIV -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; divide by zero on DIVU with a=9 -> 0xFFFFFFFF after 1 cycle; REMU -> 9.
REQ-035 SHALL pass a directed overflow test: a=0x80000000, b=0xFFFFFFFF, DIV -> 0x80000000; REM -> 0.
REQ-036 SHALL pass a directed backpressure test: hold out_ready=0 for 10 cycles in DONE -> out stable and in_ready=0; raise out_ready -> IDLE next cycle.
REQ-037 SHALL pass a directed reset test: assert reset at iteration 10 of a DIVU -> out_valid=0 immediately; a new ADD 1+1 after release -> out=2.
